psdram_arbiter: RTL and testbench

Shares the single asynchronous-mode PSDRAM port between two requesters: the video line-prefetch engine (read port) and the frame-buffer writer (write port). Owns every PSDRAM control pin (MemAdr, MemOE, MemWR, RamCE, RamLB, RamUB, data-bus drive enable) and sequences each access with a fixed, parameterised cycle count. Reads have fixed priority so the display line buffer is always refilled before the line swap. Sits between the VGA fetch logic and the top-level PSDRAM pads.

---
 rtl/psdram_arbiter.sv | 171 +++++++++++++++++
 tb/tb_psdram_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psdram_arbiter.sv
// rtl/psdram_arbiter.sv - read-priority arbiter and access sequencer for the async PSDRAM port
module psdram_arbiter #(
  parameter int ACCESS_CYCLES   = 7,
  parameter int RECOVERY_CYCLES = 1,
  parameter int ADDR_W          = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [15:0]       rd_data,
  output logic              rd_ack,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic [1:0]        wr_be,
  output logic              wr_ack,
  output logic              busy,
  output logic [ADDR_W-1:0] MemAdr,
  output logic              MemOE,
  output logic              MemWR,
  output logic              RamCE,
  output logic              RamLB,
  output logic              RamUB,
  output logic [15:0]       MemDataOut,
  output logic              MemDataOe,
  input  logic [15:0]       MemDataIn
);

  typedef enum logic [1:0] {IDLE, RD_ACCESS, WR_ACCESS, RECOVER} state_t;

  localparam logic [3:0] ACC_LOAD = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] REC_LOAD = 4'(RECOVERY_CYCLES - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [1:0]        be_q, be_nxt;
  logic [ADDR_W-1:0] adr_nxt;
  logic [15:0]       dout_nxt;
  logic [15:0]       rd_data_nxt;
  logic              rd_ack_nxt, wr_ack_nxt, busy_nxt;
  logic              oe_n_nxt, we_n_nxt, ce_n_nxt, lb_n_nxt, ub_n_nxt, doe_nxt;

  // State and phase counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state plus next value of every pin; pins are decoded from the
  // next state so they are registered and line up with the state they belong to
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    adr_nxt     = MemAdr;
    dout_nxt    = MemDataOut;
    be_nxt      = be_q;
    rd_data_nxt = rd_data;
    rd_ack_nxt  = 1'b0;
    wr_ack_nxt  = 1'b0;
    oe_n_nxt    = 1'b1;
    we_n_nxt    = 1'b1;
    ce_n_nxt    = 1'b1;
    lb_n_nxt    = 1'b1;
    ub_n_nxt    = 1'b1;
    doe_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (rd_req) begin
          state_nxt = RD_ACCESS;
          cnt_nxt   = ACC_LOAD;
          adr_nxt   = rd_addr;
        end else if (wr_req) begin
          state_nxt = WR_ACCESS;
          cnt_nxt   = ACC_LOAD;
          adr_nxt   = wr_addr;
          dout_nxt  = wr_data;
          be_nxt    = wr_be;
        end
      end
      RD_ACCESS: begin
        if (cnt == 4'd0) begin
          state_nxt   = RECOVER;
          cnt_nxt     = REC_LOAD;
          rd_data_nxt = MemDataIn;
          rd_ack_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      WR_ACCESS: begin
        if (cnt == 4'd0) begin
          state_nxt  = RECOVER;
          cnt_nxt    = REC_LOAD;
          wr_ack_nxt = 1'b1;
          // keep driving the bus one cycle past the WE rising edge for data hold
          doe_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RECOVER: begin
        if (cnt == 4'd0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    case (state_nxt)
      RD_ACCESS: begin
        ce_n_nxt = 1'b0;
        oe_n_nxt = 1'b0;
        lb_n_nxt = 1'b0;
        ub_n_nxt = 1'b0;
      end
      WR_ACCESS: begin
        ce_n_nxt = 1'b0;
        we_n_nxt = 1'b0;
        lb_n_nxt = ~be_nxt[0];
        ub_n_nxt = ~be_nxt[1];
        doe_nxt  = 1'b1;
      end
      default: ;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // Registered pins, acks and captured read data
  always_ff @(posedge clk) begin
    if (reset) begin
      MemAdr     <= '0;
      MemDataOut <= 16'd0;
      be_q       <= 2'd0;
      rd_data    <= 16'd0;
      rd_ack     <= 1'b0;
      wr_ack     <= 1'b0;
      busy       <= 1'b0;
      MemOE      <= 1'b1;
      MemWR      <= 1'b1;
      RamCE      <= 1'b1;
      RamLB      <= 1'b1;
      RamUB      <= 1'b1;
      MemDataOe  <= 1'b0;
    end else begin
      MemAdr     <= adr_nxt;
      MemDataOut <= dout_nxt;
      be_q       <= be_nxt;
      rd_data    <= rd_data_nxt;
      rd_ack     <= rd_ack_nxt;
      wr_ack     <= wr_ack_nxt;
      busy       <= busy_nxt;
      MemOE      <= oe_n_nxt;
      MemWR      <= we_n_nxt;
      RamCE      <= ce_n_nxt;
      RamLB      <= lb_n_nxt;
      RamUB      <= ub_n_nxt;
      MemDataOe  <= doe_nxt;
    end
  end

endmodule

// File: tb/tb_psdram_arbiter.sv
// tb/tb_psdram_arbiter.sv - scoreboard bench for psdram_arbiter
module tb_psdram_arbiter;

  typedef struct {
    bit          is_wr;
    logic [22:0] addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_b_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_req = 1'b0, wr_req = 1'b0;
  logic [22:0] rd_addr = '0, wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_be = '0;
  logic [15:0] rd_data, MemDataOut;
  logic        rd_ack, wr_ack, busy;
  logic [22:0] MemAdr;
  logic        MemOE, MemWR, RamCE, RamLB, RamUB, MemDataOe;
  logic [15:0] mem_in = '0;

  logic        rd_req_b = 1'b0;
  logic [22:0] rd_addr_b = '0;
  logic        zero_bit = 1'b0;
  logic [22:0] zero_addr = '0;
  logic [15:0] zero_data = '0;
  logic [1:0]  zero_be = '0;
  logic [15:0] rd_data_b, MemDataOut_b;
  logic        rd_ack_b, wr_ack_b, busy_b;
  logic [22:0] MemAdr_b;
  logic        MemOE_b, MemWR_b, RamCE_b, RamLB_b, RamUB_b, MemDataOe_b;
  logic [15:0] mem_in_b = '0;

  int tests = 0;
  int errors = 0;
  int cyc = 0;
  bit run_mon = 1'b0;
  bit abort = 1'b0;
  int ce_run = 0;
  int doe_run = 0;

  exp_t   sbq[$];
  exp_b_t qb[$];
  exp_t   mon_e;
  exp_b_t mon_b;

  logic [15:0] mem [int unsigned];

  psdram_arbiter dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ack(rd_ack),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be), .wr_ack(wr_ack),
    .busy(busy), .MemAdr(MemAdr), .MemOE(MemOE), .MemWR(MemWR), .RamCE(RamCE),
    .RamLB(RamLB), .RamUB(RamUB), .MemDataOut(MemDataOut), .MemDataOe(MemDataOe),
    .MemDataIn(mem_in)
  );

  psdram_arbiter #(.ACCESS_CYCLES(2), .RECOVERY_CYCLES(1), .ADDR_W(23)) dut_b (
    .clk(clk), .reset(reset),
    .rd_req(rd_req_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_ack(rd_ack_b),
    .wr_req(zero_bit), .wr_addr(zero_addr), .wr_data(zero_data), .wr_be(zero_be), .wr_ack(wr_ack_b),
    .busy(busy_b), .MemAdr(MemAdr_b), .MemOE(MemOE_b), .MemWR(MemWR_b), .RamCE(RamCE_b),
    .RamLB(RamLB_b), .RamUB(RamUB_b), .MemDataOut(MemDataOut_b), .MemDataOe(MemDataOe_b),
    .MemDataIn(mem_in_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pat(input int unsigned a);
    logic [31:0] v;
    v = a;
    return v[15:0] ^ 16'hC3A5;
  endfunction

  function automatic logic [15:0] model_rd(input int unsigned a);
    if (mem.exists(a)) return mem[a];
    return pat(a);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // PSDRAM model: read data presented mid-cycle, byte writes taken at each edge with WE low
  always @(negedge clk) begin
    mem_in   <= (RamCE === 1'b0 && MemOE === 1'b0) ? model_rd(32'(MemAdr)) : 16'h0000;
    mem_in_b <= (RamCE_b === 1'b0 && MemOE_b === 1'b0) ? (MemAdr_b[15:0] ^ 16'h0F0F) : 16'h0000;
  end

  always @(posedge clk) begin
    logic [15:0] w;
    if (run_mon && RamCE === 1'b0 && MemWR === 1'b0) begin
      w = model_rd(32'(MemAdr));
      if (!RamLB) w[7:0] = MemDataOut[7:0];
      if (!RamUB) w[15:8] = MemDataOut[15:8];
      mem[32'(MemAdr)] = w;
    end
  end

  // Monitor: scoreboard pops on acks, bus invariants and access window lengths
  always @(negedge clk) begin
    if (run_mon) begin
      if (rd_ack === 1'b1 || wr_ack === 1'b1) begin
        if (sbq.size() == 0) begin
          check("unexpected_ack", {rd_ack, wr_ack}, 2'b00);
        end else begin
          mon_e = sbq.pop_front();
          check("ack_kind", {rd_ack, wr_ack}, mon_e.is_wr ? 2'b01 : 2'b10);
          check("ack_cycle", 64'(cyc), 64'(mon_e.cyc));
          check("adr_hold", 64'(MemAdr), 64'(mon_e.addr));
          if (mon_e.is_wr) check("wr_mem", 64'(model_rd(32'(mon_e.addr))), 64'(mon_e.data));
          else             check("rd_data", 64'(rd_data), 64'(mon_e.data));
        end
      end
      check("bus_conflict", 64'((MemDataOe && !MemOE) || (!MemOE && !MemWR)), 64'd0);
      if (!RamCE) ce_run++;
      else if (ce_run != 0) begin
        if (!abort) check("ce_window", 64'(ce_run), 64'd7);
        ce_run = 0;
      end
      if (MemDataOe) doe_run++;
      else if (doe_run != 0) begin
        if (!abort) check("doe_window", 64'(doe_run), 64'd8);
        doe_run = 0;
      end
      if (rd_ack_b === 1'b1) begin
        if (qb.size() == 0) begin
          check("unexpected_ack_b", 64'(rd_ack_b), 64'd0);
        end else begin
          mon_b = qb.pop_front();
          check("b_ack_cycle", 64'(cyc), 64'(mon_b.cyc));
          check("b_rd_data", 64'(rd_data_b), 64'(mon_b.data));
        end
      end
    end
  end

  task automatic wait_ack(input int sel, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      case (sel)
        0:       got = rd_ack;
        1:       got = wr_ack;
        default: got = rd_ack_b;
      endcase
    end
    check({name, "_ack_seen"}, 64'(got), 64'd1);
  endtask

  task automatic do_read(input logic [22:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    rd_addr = a;
    rd_req  = 1'b1;
    sbq.push_back('{is_wr: 1'b0, addr: a, data: d, cyc: cyc + 8});
    wait_ack(0, "read");
    rd_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {MemOE, MemWR, RamCE, RamLB, RamUB, busy, rd_ack, wr_ack, MemDataOe}, 9'b111110000);
    check("reset_data", {MemAdr, rd_data, MemDataOut}, 64'd0);
    @(posedge clk); #1;
    reset   = 1'b0;
    run_mon = 1'b1;

    // single read
    mem[32'h140] = 16'hA55A;
    do_read(23'h000140, 16'hA55A);

    // single write, low byte only
    @(posedge clk); #1;
    wr_addr = 23'h012345; wr_data = 16'hBEEF; wr_be = 2'b01; wr_req = 1'b1;
    sbq.push_back('{is_wr: 1'b1, addr: 23'h012345, data: 16'hE0EF, cyc: cyc + 8});
    repeat (4) @(negedge clk);
    check("wr_pins", {RamCE, MemOE, MemWR, RamLB, RamUB, MemDataOe, MemDataOut}, {6'b010011, 16'hBEEF});
    wait_ack(1, "write");
    wr_req = 1'b0;

    // simultaneous requests: read first, write 9 cycles later
    @(posedge clk); #1;
    rd_addr = 23'h200; rd_req = 1'b1;
    wr_addr = 23'h300; wr_data = 16'h1234; wr_be = 2'b11; wr_req = 1'b1;
    sbq.push_back('{is_wr: 1'b0, addr: 23'h200, data: 16'hC1A5, cyc: cyc + 8});
    sbq.push_back('{is_wr: 1'b1, addr: 23'h300, data: 16'h1234, cyc: cyc + 17});
    fork
      begin wait_ack(0, "sim_read"); rd_req = 1'b0; end
      begin wait_ack(1, "sim_write"); wr_req = 1'b0; end
    join

    // 320-word burst with a starved writer
    @(posedge clk); #1;
    s = cyc;
    rd_addr = 23'h1000; rd_req = 1'b1;
    wr_addr = 23'h2000; wr_data = 16'h0BAD; wr_be = 2'b10; wr_req = 1'b1;
    for (int i = 0; i < 320; i++)
      sbq.push_back('{is_wr: 1'b0, addr: 23'(32'h1000 + i), data: pat(32'h1000 + i), cyc: s + 8 + 9 * i});
    sbq.push_back('{is_wr: 1'b1, addr: 23'h2000, data: 16'h0BA5, cyc: s + 8 + 9 * 320});
    for (int i = 0; i < 320; i++) begin
      wait_ack(0, "burst_read");
      if (i < 319) rd_addr = 23'(32'h1000 + i + 1);
      else         rd_req = 1'b0;
    end
    wait_ack(1, "burst_write");
    wr_req = 1'b0;

    // reset in the 4th access cycle of a write
    @(posedge clk); #1;
    abort = 1'b1;
    wr_addr = 23'h400; wr_data = 16'h5555; wr_be = 2'b11; wr_req = 1'b1;
    repeat (4) @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; wr_req = 1'b0;
    @(negedge clk);
    check("abort_pins", {RamCE, MemOE, MemWR, RamLB, RamUB, MemDataOe, busy, wr_ack}, 8'b11111000);
    repeat (12) @(negedge clk);
    abort = 1'b0;
    do_read(23'h000500, 16'hC6A5);

    // short-timing instance: latency 3, period 4
    @(posedge clk); #1;
    s = cyc;
    rd_addr_b = 23'd1; rd_req_b = 1'b1;
    qb.push_back('{data: 16'h0F0E, cyc: s + 3});
    qb.push_back('{data: 16'h0F0D, cyc: s + 7});
    qb.push_back('{data: 16'h0F0C, cyc: s + 11});
    for (int i = 0; i < 3; i++) begin
      wait_ack(2, "short_read");
      if (i < 2) rd_addr_b = 23'(i + 2);
      else       rd_req_b = 1'b0;
    end

    repeat (5) @(negedge clk);
    check("pending_expects", 64'(sbq.size() + qb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
